// File: rtl/arbitro_pop_scheduler.sv
// Pops VC0/VC1 with VC0 strict priority plus a VC1 starvation guard, and routes each word to D0/D1.
// Latency: pop in cycle n -> registered push visible in cycle n+2; one word per cycle.
// Backpressure: either D pause stalls all new pops; the up-to-2 words already in flight still push.
module arbitro_pop_scheduler #(
    parameter int DATA_W    = 6,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] VC0,
    input  logic [DATA_W-1:0] VC1,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic              D0_pause,
    input  logic              D1_pause,
    output logic              VC0_pop,
    output logic              VC1_pop,
    output logic              D0_push,
    output logic              D1_push,
    output logic [DATA_W-1:0] D0,
    output logic [DATA_W-1:0] D1,
    output logic              grant_vc1
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SRV0  = 2'b01,
        SRV1  = 2'b10,
        STALL = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        burst_cnt;
    logic              stall;
    logic              force_vc1;
    logic              pop_d0;
    logic              pop_d1;
    logic              word_vld;
    logic [DATA_W-1:0] word;

    assign stall     = D0_pause | D1_pause;
    assign force_vc1 = (burst_cnt == MAX_B) & ~VC1_empty;

    // Read data arrives the cycle after the pop, so the delayed pop selects which VC bus to take.
    assign word_vld  = pop_d0 | pop_d1;
    assign word      = pop_d1 ? VC1 : VC0;

    // The state reflects the grant issued in the previous cycle; SRV1 doubles as the debug flag.
    assign grant_vc1 = (state == SRV1);

    // State register: records what was granted this cycle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a stall dominates, otherwise follow whichever VC was granted.
    always_comb begin
        state_nxt = IDLE;
        if (stall) begin
            state_nxt = STALL;
        end else if (VC0_pop) begin
            state_nxt = SRV0;
        end else if (VC1_pop) begin
            state_nxt = SRV1;
        end
    end

    // Grant outputs: forced VC1 first, then VC0 priority, then VC1; pops are gated by !empty.
    always_comb begin
        VC0_pop = 1'b0;
        VC1_pop = 1'b0;
        if (reset_L && !stall) begin
            if (force_vc1) begin
                VC1_pop = 1'b1;
            end else if (!VC0_empty) begin
                VC0_pop = 1'b1;
            end else if (!VC1_empty) begin
                VC1_pop = 1'b1;
            end
        end
    end

    // Burst counter: counts VC0 grants made while VC1 is waiting; it holds across stalls.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            burst_cnt <= '0;
        end else if (VC1_pop || VC1_empty) begin
            burst_cnt <= '0;
        end else if (VC0_pop && (burst_cnt != MAX_B)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    // Pop pipeline: remembers which VC was popped so its read data can be captured next cycle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pop_d0 <= 1'b0;
            pop_d1 <= 1'b0;
        end else begin
            pop_d0 <= VC0_pop;
            pop_d1 <= VC1_pop;
        end
    end

    // Output stage: route by word bit DATA_W-2; the non-selected D keeps its last value.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            D0_push <= 1'b0;
            D1_push <= 1'b0;
            D0      <= '0;
            D1      <= '0;
        end else begin
            D0_push <= word_vld & ~word[DATA_W-2];
            D1_push <= word_vld &  word[DATA_W-2];
            if (word_vld && !word[DATA_W-2]) begin
                D0 <= word;
            end
            if (word_vld && word[DATA_W-2]) begin
                D1 <= word;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_pop_scheduler.sv
// Bench for arbitro_pop_scheduler: VC FIFOs modelled as queues, expected pushes as a timed event list.
// Each cycle inputs are driven 1ns after posedge and outputs are sampled at negedge.
// Directed table, hand-written corner sequences, then a randomized run with pauses and resets.
module tb_arbitro_pop_scheduler;

    localparam int DATA_W    = 6;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [DATA_W-1:0] VC0 = '0;
    logic [DATA_W-1:0] VC1 = '0;
    logic              VC0_empty = 1'b1;
    logic              VC1_empty = 1'b1;
    logic              D0_pause = 1'b0;
    logic              D1_pause = 1'b0;
    logic              VC0_pop;
    logic              VC1_pop;
    logic              D0_push;
    logic              D1_push;
    logic [DATA_W-1:0] D0;
    logic [DATA_W-1:0] D1;
    logic              grant_vc1;

    always #5 clk = ~clk;

    arbitro_pop_scheduler #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .VC0       (VC0),
        .VC1       (VC1),
        .VC0_empty (VC0_empty),
        .VC1_empty (VC1_empty),
        .D0_pause  (D0_pause),
        .D1_pause  (D1_pause),
        .VC0_pop   (VC0_pop),
        .VC1_pop   (VC1_pop),
        .D0_push   (D0_push),
        .D1_push   (D1_push),
        .D0        (D0),
        .D1        (D1),
        .grant_vc1 (grant_vc1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment: VC FIFO contents and their registered read-data buses.
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] rd0 = '0;
    logic [DATA_W-1:0] rd1 = '0;
    logic              pause0 = 1'b0;
    logic              pause1 = 1'b0;
    logic              rst_n = 1'b0;

    // Reference model: expected pushes are timed events (word popped at cycle n lands at n+2).
    typedef struct {
        int                due;
        logic [DATA_W-1:0] w;
    } ev_t;
    ev_t               sched[$];
    int                cyc = 0;
    int                m_burst = 0;
    bit                m_last_vc1 = 1'b0;
    bit                m_p0 = 1'b0;
    bit                m_p1 = 1'b0;
    bit                model_valid = 1'b0;
    logic [DATA_W-1:0] m_d0 = '0;
    logic [DATA_W-1:0] m_d1 = '0;

    // Values sampled from the DUT in the most recent cycle.
    logic              s_pop0, s_pop1, s_push0, s_push1, s_g;
    logic [DATA_W-1:0] s_d0, s_d1;

    // One clock cycle: drive, sample and check, then advance the model and the FIFOs.
    task automatic run_cycle();
        bit  e0, e1, stall, force1, g0, g1;
        ev_t ev;
        reset_L   = rst_n;
        VC0       = rd0;
        VC1       = rd1;
        D0_pause  = pause0;
        D1_pause  = pause1;
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        stall  = pause0 | pause1;
        force1 = (m_burst == MAX_BURST) && !e1;
        g1 = rst_n && !stall && (force1 || (e0 && !e1));
        g0 = rst_n && !stall && !force1 && !e0;

        @(negedge clk);
        s_pop0  = VC0_pop;
        s_pop1  = VC1_pop;
        s_push0 = D0_push;
        s_push1 = D1_push;
        s_d0    = D0;
        s_d1    = D1;
        s_g     = grant_vc1;
        chk("VC0_pop", 32'(s_pop0), 32'(g0));
        chk("VC1_pop", 32'(s_pop1), 32'(g1));
        if (model_valid) begin
            chk("D0_push", 32'(s_push0), 32'(m_p0));
            chk("D1_push", 32'(s_push1), 32'(m_p1));
            chk("D0", 32'(s_d0), 32'(m_d0));
            chk("D1", 32'(s_d1), 32'(m_d1));
            chk("grant_vc1", 32'(s_g), 32'(m_last_vc1));
        end

        @(posedge clk);
        #1;
        if (!rst_n) begin
            sched.delete();
            m_burst     = 0;
            m_last_vc1  = 1'b0;
            m_d0        = '0;
            m_d1        = '0;
            model_valid = 1'b1;
        end else begin
            if (g0) begin
                ev.due = cyc + 2;
                ev.w   = q0[0];
                sched.push_back(ev);
            end
            if (g1) begin
                ev.due = cyc + 2;
                ev.w   = q1[0];
                sched.push_back(ev);
            end
            if (g1 || e1) m_burst = 0;
            else if (g0 && m_burst < MAX_BURST) m_burst++;
            m_last_vc1 = g1;
        end
        cyc++;
        m_p0 = 1'b0;
        m_p1 = 1'b0;
        while (sched.size() > 0 && sched[0].due == cyc) begin
            ev = sched.pop_front();
            if (ev.w[DATA_W-2]) begin
                m_p1 = 1'b1;
                m_d1 = ev.w;
            end else begin
                m_p0 = 1'b1;
                m_d0 = ev.w;
            end
        end
        if (s_pop0 === 1'b1 && q0.size() > 0) rd0 = q0.pop_front();
        if (s_pop1 === 1'b1 && q1.size() > 0) rd1 = q1.pop_front();
    endtask

    typedef struct {
        bit                vc1;
        logic [DATA_W-1:0] w;
        bit                p0, p1, ps0, ps1, g;
        logic [DATA_W-1:0] d0, d1;
    } vec_t;
    vec_t tbl[6];

    logic [9:0] pat;

    initial begin
        // {vc1, word, pop0, pop1, push0, push1, grant_vc1, D0, D1}
        tbl[0] = '{1'b0, 6'h21, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h21, 6'h15};
        tbl[1] = '{1'b1, 6'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'h21, 6'h33};
        tbl[2] = '{1'b1, 6'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0A, 6'h33};
        tbl[3] = '{1'b0, 6'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0A, 6'h1F};
        tbl[4] = '{1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h1F};
        tbl[5] = '{1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'h00, 6'h3F};

        @(posedge clk);
        #1;

        // Reset held for 2 cycles with VC0 non-empty.
        rst_n = 1'b0;
        q0.push_back(6'h05);
        q0.push_back(6'h15);
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            chk("rst_pop0", 32'(s_pop0), 32'd0);
            chk("rst_pop1", 32'(s_pop1), 32'd0);
        end
        chk("rst_push0", 32'(s_push0), 32'd0);
        chk("rst_push1", 32'(s_push1), 32'd0);
        chk("rst_D0", 32'(s_d0), 32'd0);
        chk("rst_D1", 32'(s_d1), 32'd0);
        chk("rst_grant", 32'(s_g), 32'd0);

        // VC0 holds 0x05, 0x15: two pops, then D0 push and D1 push two cycles later.
        rst_n = 1'b1;
        run_cycle(); chk("t2_pop_c1", 32'(s_pop0), 32'd1);
        run_cycle(); chk("t2_pop_c2", 32'(s_pop0), 32'd1);
        run_cycle(); chk("t2_push0_c3", 32'(s_push0), 32'd1); chk("t2_D0_c3", 32'(s_d0), 32'h05);
        run_cycle(); chk("t2_push1_c4", 32'(s_push1), 32'd1); chk("t2_D1_c4", 32'(s_d1), 32'h15);

        // Single-word transfers from the table.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].vc1) q1.push_back(tbl[i].w);
            else q0.push_back(tbl[i].w);
            run_cycle();
            chk("tbl_pop0", 32'(s_pop0), 32'(tbl[i].p0));
            chk("tbl_pop1", 32'(s_pop1), 32'(tbl[i].p1));
            run_cycle();
            chk("tbl_grant", 32'(s_g), 32'(tbl[i].g));
            run_cycle();
            chk("tbl_push0", 32'(s_push0), 32'(tbl[i].ps0));
            chk("tbl_push1", 32'(s_push1), 32'(tbl[i].ps1));
            chk("tbl_D0", 32'(s_d0), 32'(tbl[i].d0));
            chk("tbl_D1", 32'(s_d1), 32'(tbl[i].d1));
        end

        // Both VCs busy: VC1 is forced after every 4 VC0 grants.
        for (int i = 0; i < 10; i++) q0.push_back(6'($urandom));
        for (int i = 0; i < 3; i++) q1.push_back(6'($urandom));
        pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            chk("burst_pop1", 32'(s_pop1), 32'(pat[i]));
            chk("burst_pop0", 32'(s_pop0), 32'(!pat[i]));
            if (i > 0) chk("burst_grant", 32'(s_g), 32'(pat[i-1]));
        end
        for (int i = 0; i < 8; i++) run_cycle();

        // D1_pause rises in cycle 2 of a stream; the 2 in-flight words still land.
        for (int i = 0; i < 6; i++) q0.push_back(6'($urandom));
        run_cycle(); chk("pz_pop_c0", 32'(s_pop0), 32'd1);
        run_cycle(); chk("pz_pop_c1", 32'(s_pop0), 32'd1);
        pause1 = 1'b1;
        run_cycle();
        chk("pz_nopop_c2", 32'(s_pop0 | s_pop1), 32'd0);
        chk("pz_push_c2", 32'(s_push0 | s_push1), 32'd1);
        run_cycle();
        chk("pz_nopop_c3", 32'(s_pop0 | s_pop1), 32'd0);
        chk("pz_push_c3", 32'(s_push0 | s_push1), 32'd1);
        run_cycle();
        chk("pz_nopush_c4", 32'(s_push0 | s_push1), 32'd0);
        pause1 = 1'b0;
        run_cycle(); chk("pz_resume_c5", 32'(s_pop0), 32'd1);
        for (int i = 0; i < 8; i++) run_cycle();

        // Reset one cycle after a VC1 pop discards the in-flight word.
        q1.push_back(6'h30);
        run_cycle(); chk("rm_pop1", 32'(s_pop1), 32'd1);
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        run_cycle();
        chk("rm_push0", 32'(s_push0), 32'd0);
        chk("rm_push1", 32'(s_push1), 32'd0);
        chk("rm_D0", 32'(s_d0), 32'd0);
        chk("rm_D1", 32'(s_d1), 32'd0);
        chk("rm_grant", 32'(s_g), 32'd0);
        run_cycle();
        chk("rm_push1_late", 32'(s_push1), 32'd0);

        // VC0 runs dry at burst 3: VC1 served, and the count restarts from 0.
        for (int i = 0; i < 3; i++) q0.push_back(6'($urandom));
        for (int i = 0; i < 2; i++) q1.push_back(6'($urandom));
        for (int i = 0; i < 3; i++) begin
            run_cycle(); chk("dry_pop0", 32'(s_pop0), 32'd1);
        end
        run_cycle(); chk("dry_pop1", 32'(s_pop1), 32'd1);
        for (int i = 0; i < 5; i++) q0.push_back(6'($urandom));
        for (int i = 0; i < 4; i++) begin
            run_cycle(); chk("dry_refill_pop0", 32'(s_pop0), 32'd1);
        end
        run_cycle(); chk("dry_force_pop1", 32'(s_pop1), 32'd1);
        for (int i = 0; i < 6; i++) run_cycle();

        // Randomized traffic with pauses and occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) q0.push_back(6'($urandom));
            if ($urandom_range(0, 3) == 0) q1.push_back(6'($urandom));
            pause0 = ($urandom_range(0, 9) == 0);
            pause1 = ($urandom_range(0, 9) == 0);
            rst_n  = ($urandom_range(0, 79) != 0);
            run_cycle();
        end
        pause0 = 1'b0;
        pause1 = 1'b0;
        rst_n  = 1'b1;
        for (int n = 0; n < 400 && (q0.size() > 0 || q1.size() > 0 || sched.size() > 0); n++) run_cycle();
        run_cycle();
        run_cycle();
        chk("drain_q0_empty", 32'(q0.size()), 32'd0);
        chk("drain_q1_empty", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
